// File: rtl/banner_sprite.sv
// banner_sprite: text-banner sprite for the VGA pipeline.
// Renders NUM_CHARS glyphs from a writable bitmap RAM, each glyph cell drawn
// as a SCALE x SCALE block, moving from START_ROW to STOP_ROW one STEP per
// motion tick and then holding (optionally blinking).
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   pixel_row/column     current scan position
//   enable, mode         run control; mode latched on leaving IDLE
//   fg_color             colour driven on lit pixels
//   glyph_we/waddr/wdata glyph RAM write port (addr = char*GLYPH_H + row)
//   pixel_on/pixel_color registered render outputs (1 cycle latency)
//   done                 banner sits at STOP_ROW
module banner_sprite #(
  parameter int unsigned NUM_CHARS   = 8,
  parameter int unsigned GLYPH_W     = 5,
  parameter int unsigned GLYPH_H     = 7,
  parameter int unsigned SCALE       = 10,
  parameter int unsigned CHAR_GAP    = 1,
  parameter int unsigned TICK_DIV    = 4000000,
  parameter int unsigned STEP        = 3,
  parameter int unsigned START_ROW   = 480,
  parameter int unsigned STOP_ROW    = 100,
  parameter int unsigned START_COL   = 195,
  parameter int unsigned BLINK_TICKS = 16,
  parameter int unsigned COLOR_W     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [11:0]                            pixel_row,
  input  logic [11:0]                            pixel_column,
  input  logic                                   enable,
  input  logic [1:0]                             mode,
  input  logic [COLOR_W-1:0]                     fg_color,
  input  logic                                   glyph_we,
  input  logic [$clog2(NUM_CHARS*GLYPH_H)-1:0]   glyph_waddr,
  input  logic [GLYPH_W-1:0]                     glyph_wdata,
  output logic                                   pixel_on,
  output logic [COLOR_W-1:0]                     pixel_color,
  output logic                                   done
);

  localparam int unsigned DEPTH = NUM_CHARS * GLYPH_H;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [12:0] H13       = 13'(GLYPH_H * SCALE);
  localparam logic [12:0] W13       = 13'(NUM_CHARS * (GLYPH_W + CHAR_GAP) * SCALE);
  localparam logic [12:0] SCALE13   = 13'(SCALE);
  localparam logic [12:0] PITCH13   = 13'(GLYPH_W + CHAR_GAP);
  localparam logic [12:0] GH13      = 13'(GLYPH_H);
  localparam logic [12:0] GW13      = 13'(GLYPH_W);
  localparam logic [12:0] COL0      = 13'(START_COL);
  localparam logic [12:0] ROW_START = 13'(START_ROW);
  localparam logic [12:0] ROW_STOP  = 13'(STOP_ROW);
  localparam logic [12:0] STEP13    = 13'(STEP);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam bit DOWN = (STOP_ROW <= START_ROW);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  state_t          state_q, state_n;
  logic [12:0]     row_q, row_n;
  logic            done_q, done_n;
  logic            vis_q, vis_n;
  logic [1:0]      mode_q, mode_n;
  logic [BW-1:0]   bcnt_q, bcnt_n;
  logic [TW-1:0]   tcnt_q;
  logic            tick;

  logic [GLYPH_W-1:0] glyph_ram [DEPTH];

  // Glyph RAM is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (glyph_we) glyph_ram[glyph_waddr] <= glyph_wdata;
  end

  assign tick = (state_q != IDLE) && (tcnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tcnt_q <= '0;
    else if (state_q == IDLE) tcnt_q <= '0;
    else if (tick)            tcnt_q <= '0;
    else                      tcnt_q <= tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= ROW_START;
      done_q  <= 1'b0;
      vis_q   <= 1'b1;
      mode_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      done_q  <= done_n;
      vis_q   <= vis_n;
      mode_q  <= mode_n;
      bcnt_q  <= bcnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    done_n  = done_q;
    vis_n   = vis_q;
    mode_n  = mode_q;
    bcnt_n  = bcnt_q;
    case (state_q)
      IDLE: begin
        row_n  = ROW_START;
        done_n = 1'b0;
        vis_n  = 1'b1;
        bcnt_n = '0;
        if (enable) begin
          mode_n = mode;
          // Modes 01/10 scroll; 00/11 jump straight to the stop row.
          if (mode[0] ^ mode[1]) begin
            state_n = MOVE;
          end else begin
            state_n = HOLD;
            row_n   = ROW_STOP;
            done_n  = 1'b1;
          end
        end
      end
      MOVE: begin
        if (tick) begin
          // Clamp test is arranged so the subtraction can never wrap.
          if (DOWN ? (row_q <= ROW_STOP + STEP13) : (row_q + STEP13 >= ROW_STOP)) begin
            row_n   = ROW_STOP;
            done_n  = 1'b1;
            vis_n   = 1'b1;
            bcnt_n  = '0;
            state_n = HOLD;
          end else begin
            row_n = DOWN ? (row_q - STEP13) : (row_q + STEP13);
          end
        end
      end
      HOLD: begin
        if (!mode_q[1]) begin
          vis_n = 1'b1;
        end else if (tick) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_n = '0;
            vis_n  = ~vis_q;
          end else begin
            bcnt_n = bcnt_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      row_n   = ROW_START;
      done_n  = 1'b0;
      vis_n   = 1'b1;
      bcnt_n  = '0;
    end
  end

  logic [12:0]        pr, pc, dr, dc, ch, gx;
  logic [AW-1:0]      addr;
  logic [GLYPH_W-1:0] rdata;
  logic               in_rows, in_cols, cell_bit, hit;

  always_comb begin
    pr       = {1'b0, pixel_row};
    pc       = {1'b0, pixel_column};
    in_rows  = (pr >= row_q) && (pr < row_q + H13);
    in_cols  = (pc >= COL0) && (pc < COL0 + W13);
    dr       = (pr - row_q) / SCALE13;
    dc       = (pc - COL0) / SCALE13;
    ch       = dc / PITCH13;
    gx       = dc % PITCH13;
    addr     = AW'(ch * GH13 + dr);
    rdata    = glyph_ram[addr];
    cell_bit = 1'b0;
    // Cell gx maps to bit GLYPH_W-1-gx (leftmost cell is the MSB).
    for (int unsigned i = 0; i < GLYPH_W; i++) begin
      if (gx == 13'(GLYPH_W - 1 - i)) cell_bit = rdata[i];
    end
    hit = in_rows && in_cols && (gx < GW13) && cell_bit && vis_q && (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_on    <= 1'b0;
      pixel_color <= '0;
    end else begin
      pixel_on    <= hit;
      pixel_color <= hit ? fg_color : '0;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_banner_sprite.sv
module tb_banner_sprite;
  localparam int TDIV = 4;
  localparam int BT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_row, pixel_column;
  logic        enable;
  logic [1:0]  mode;
  logic [3:0]  fg_color, pixel_color;
  logic        glyph_we;
  logic [5:0]  glyph_waddr;
  logic [4:0]  glyph_wdata;
  logic        pixel_on, done;

  always #5 clk = ~clk;

  banner_sprite #(.TICK_DIV(TDIV), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
    .enable(enable), .mode(mode), .fg_color(fg_color), .glyph_we(glyph_we),
    .glyph_waddr(glyph_waddr), .glyph_wdata(glyph_wdata), .pixel_on(pixel_on),
    .pixel_color(pixel_color), .done(done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: glyph contents plus time since the banner was started.
  logic [4:0] mram [56];
  bit         act = 0;
  logic [1:0] mode_m = 0;
  int         t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic int m_row();
    int r;
    if (!act) return 480;
    if (mode_m == 2'd1 || mode_m == 2'd2) begin
      r = 480 - 3 * (t / TDIV);
      return (r < 100) ? 100 : r;
    end
    return 100;
  endfunction

  function automatic bit m_done();
    if (!act) return 0;
    if (mode_m == 2'd0 || mode_m == 2'd3) return 1;
    return (480 - 3 * (t / TDIV)) <= 100;
  endfunction

  function automatic bit m_vis();
    int h0, k;
    if (!act || mode_m < 2) return 1;
    h0 = (mode_m == 2'd3) ? 0 : 127;   // tick on which the banner lands
    k  = t / TDIV;
    if (k < h0) return 1;
    return ((k - h0) / BT) % 2 == 0;
  endfunction

  function automatic bit m_pix(input int r, input int c);
    int rp, dr, dc, gx;
    logic [4:0] g;
    rp = m_row();
    if (!act || !m_vis()) return 0;
    if (r < rp || r >= rp + 70) return 0;
    if (c < 195 || c >= 195 + 480) return 0;
    dr = (r - rp) / 10;
    dc = (c - 195) / 10;
    gx = dc % 6;
    if (gx >= 5) return 0;
    g = mram[(dc / 6) * 7 + dr];
    return g[4 - gx];
  endfunction

  task automatic step(input int r, input int c, input bit we = 0,
                      input int wa = 0, input logic [4:0] wd = 5'd0);
    logic [3:0] fg;
    bit         exp_on, en_s;
    logic [1:0] md_s;
    fg           = 4'($urandom);
    pixel_row    = 12'(r);
    pixel_column = 12'(c);
    fg_color     = fg;
    glyph_we     = we;
    glyph_waddr  = 6'(wa);
    glyph_wdata  = wd;
    exp_on       = m_pix(r, c);
    en_s         = enable;
    md_s         = mode;
    @(posedge clk);
    #1;
    if (we) mram[wa] = wd;
    if (!act && en_s) begin
      act = 1; mode_m = md_s; t = 0;
    end else if (act && !en_s) begin
      act = 0;
    end else if (act) begin
      t++;
    end
    glyph_we = 1'b0;
    check("pixel_on", pixel_on, exp_on);
    check("pixel_color", pixel_color, exp_on ? fg : 4'd0);
    check("done", done, m_done());
  endtask

  task automatic run(input int n);
    int rp;
    for (int i = 0; i < n; i++) begin
      rp = m_row();
      step(rp - 3 + int'($urandom_range(0, 76)), int'($urandom_range(185, 685)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] old;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; pixel_row = '0; pixel_column = '0;
    fg_color = '0; glyph_we = 1'b0; glyph_waddr = '0; glyph_wdata = '0;
    #12;
    check("rst_pixel_on", pixel_on, 0);
    check("rst_pixel_color", pixel_color, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 56; i++)
      step(0, 0, 1, i, (i == 0) ? 5'b10001 : 5'($urandom));

    // Static render.
    mode = 2'd0; enable = 1'b1;
    step(100, 195);
    step(100, 195); step(100, 205); step(100, 235); step(99, 195);
    step(100, 245); step(169, 195); step(170, 195);
    step(100, 674); step(100, 675); step(100, 194);
    old = mram[49];
    step(100, 655, 1, 49, ~old);
    step(100, 655);
    run(200);

    // Scroll, drop enable at row 300, restart; mode changes mid-run ignored.
    enable = 1'b0; run(1);
    mode = 2'd1; enable = 1'b1; run(1);
    mode = 2'd0; run(240);
    enable = 1'b0; run(2);
    mode = 2'd1; enable = 1'b1; run(540);

    // Scroll then blink.
    enable = 1'b0; run(1);
    mode = 2'd2; enable = 1'b1; run(560);

    // Blink-static with a steady lit probe.
    enable = 1'b0; run(1);
    mode = 2'd3; enable = 1'b1;
    for (int i = 0; i < 40; i++) step(100, 195);

    // Asynchronous reset between edges during MOVE.
    enable = 1'b0; run(1);
    mode = 2'd1; enable = 1'b1; run(50);
    step(m_row(), 195);
    #3 rst = 1'b1;
    #1;
    check("async_rst_pixel_on", pixel_on, 0);
    check("async_rst_pixel_color", pixel_color, 0);
    check("async_rst_done", done, 0);
    act = 0; t = 0;
    #1 rst = 1'b0;
    run(20);

    // Glyph contents survive reset.
    enable = 1'b0; run(1);
    mode = 2'd0; enable = 1'b1; run(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/banner_sprite.md
Name: banner_sprite

Overview:
Parametrised text-banner sprite for the VGA pipeline. Renders NUM_CHARS glyphs from a writable bitmap RAM, each glyph pixel scaled to a SCALE x SCALE block. The banner moves from a start row to a stop row at a programmable tick rate, then holds or blinks. It sits beside the other sprite generators and feeds a COLOR_W-bit value to the VGA colour mux. It is intended for win, lose and title screens.

Parameters:
NUM_CHARS, 8, glyphs in the banner
GLYPH_W, 5, glyph width in cells (bit GLYPH_W-1 is the leftmost cell)
GLYPH_H, 7, glyph height in cells
SCALE, 10, screen pixels per cell edge
CHAR_GAP, 1, blank cells between glyphs
TICK_DIV, 4000000, clocks per motion tick
STEP, 3, rows moved per tick
START_ROW, 480, initial banner top row
STOP_ROW, 100, final banner top row
START_COL, 195, banner left column (fixed)
BLINK_TICKS, 16, ticks per blink half-period
COLOR_W, 4, colour width

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-high
pixel_row  in  12  current scan row
pixel_column  in  12  current scan column
enable  in  1  banner active; low returns the block to IDLE
mode  in  2  00 static, 01 scroll, 10 scroll-then-blink, 11 blink-static
fg_color  in  COLOR_W  colour driven when the pixel is on
glyph_we  in  1  glyph RAM write strobe
glyph_waddr  in  clog2(NUM_CHARS*GLYPH_H)  address = char*GLYPH_H + glyph row
glyph_wdata  in  GLYPH_W  glyph row bits
pixel_on  out  1  banner covers the pixel (registered)
pixel_color  out  COLOR_W  fg_color when pixel_on, else 0 (registered)
done  out  1  banner has reached STOP_ROW (level)

Behaviour:
- Reset values: pixel_on=0, pixel_color=0, done=0, state=IDLE, row_pos=START_ROW, tick counter=0, visible=1. Glyph RAM is not reset and keeps its contents through rst.
- Geometry, evaluated against the current row_pos:
  - Banner height H = GLYPH_H*SCALE.
  - Banner width W = NUM_CHARS*(GLYPH_W+CHAR_GAP)*SCALE.
  - Bounds are inclusive at the top/left and exclusive at the bottom/right: row_pos <= pixel_row < row_pos+H and START_COL <= pixel_column < START_COL+W.
  - Cell coordinates: dr = (pixel_row-row_pos)/SCALE; dc = (pixel_column-START_COL)/SCALE.
  - ch = dc/(GLYPH_W+CHAR_GAP); gx = dc mod (GLYPH_W+CHAR_GAP).
  - gx >= GLYPH_W is a gap cell and is off. Otherwise the bit is glyph_ram[ch*GLYPH_H+dr][GLYPH_W-1-gx].
  - All arithmetic is 13-bit unsigned with no wrap.
- Latency: pixel_on and pixel_color are registered exactly 1 cycle after pixel_row/pixel_column. pixel_on = in-bounds AND glyph bit AND visible AND (state != IDLE).
- Glyph RAM: write on the clk edge when glyph_we=1. The written data is visible to any lookup computed on the following cycle onward. A read and a write to the same address in the same cycle return the old data.
- Tick counter:
  - Runs only when state != IDLE.
  - Counts 0..TICK_DIV-1, and tick=1 in the cycle it equals TICK_DIV-1, after which it wraps to 0.
  - Cleared whenever state is IDLE.
- FSM states: IDLE, MOVE, HOLD.
  - IDLE: row_pos=START_ROW, done=0, visible=1. On enable=1, mode is latched (mode_q).
    - mode_q 01 or 10: go to MOVE.
    - mode_q 00 or 11: go to HOLD with row_pos=STOP_ROW and done=1 on that same edge.
  - MOVE, on tick: row_pos steps STEP toward STOP_ROW (direction set by the sign of STOP_ROW-START_ROW).
    - If the step would reach or pass STOP_ROW: row_pos=STOP_ROW, done=1, go to HOLD.
  - HOLD:
    - mode_q 10 or 11: visible toggles every BLINK_TICKS ticks, starting visible.
    - Otherwise visible=1.
  - Any state with enable=0: go to IDLE on the next edge, and pixel_on=0 from the following cycle.
- mode changes while state != IDLE are ignored until the block passes through IDLE.
- Asynchronous rst mid-scroll: immediately forces the reset values. Motion restarts only when enable is seen high after rst is released.
- START_ROW == STOP_ROW: in MOVE, the first tick clamps, sets done and goes to HOLD.

Test Plan:
- Static render (mode 00, defaults, char0 row0 = 10001): the cycle after pixel (100,195) → pixel_on=1, pixel_color=fg_color. Pixel (100,205) → pixel_on=0. Pixel (100,235) → pixel_on=1. Pixel (99,195) → pixel_on=0. Pixel (100,245), a gap cell → pixel_on=0. done=1 one cycle after enable.
- Scroll (mode 01, TICK_DIV=4): row_pos decreases by 3 every 4 cycles. After tick 126 → row_pos=102. Tick 127 → row_pos=100 (clamped), done=1, state HOLD.
- Blink (mode 11, TICK_DIV=4, BLINK_TICKS=2): a steady lit pixel probe shows pixel_on high for 8 cycles, low for 8 cycles, repeating. done stays 1.
- Enable dropped mid-scroll at row_pos=300 → next cycle state IDLE, row_pos=480, done=0, pixel_on=0. Re-enable → scroll restarts from 480.
- Async rst pulse mid-MOVE, asserted between clock edges → outputs are 0 immediately. Glyph data is still intact afterwards (re-render matches the pre-reset output).
- Glyph write while displaying char 7 (last glyph): the lookup after the write edge shows the new bits. Right edge: pixel column START_COL+W-1 is evaluated and column START_COL+W is off.
